al_mode_ctrl: RTL and testbench
===============================

# al_mode_ctrl

Mode controller and increment arbiter for the alarm clock. It holds the current-time and alarm-time BCD registers and shares one BCD increment unit between the one-minute timekeeping tick and the user set-minute/set-hour buttons. It also selects the word sent to the 7-segment driver and raises the alarm output. It sits between TIME_GEN and the display driver, replacing the free-running time feedback loop.

## Interface
Parameters: none.

Ports:
- MCLK  in  1  system clock
- int_reset  in  1  asynchronous, active-high reset
- one_minute  in  1  minute tick, one MCLK cycle wide, synchronous to MCLK
- btn_min  in  1  debounced set-minute button level
- btn_hour  in  1  debounced set-hour button level
- sw_time_set  in  1  level; selects SET_TIME mode
- sw_alarm_set  in  1  level; selects SET_ALARM mode
- sw_alarm_view  in  1  level; shows the alarm word while in RUN
- alarm_en  in  1  alarm arm enable
- time_bcd  out  16  {ms_hour, ls_hour, ms_min, ls_min}, registered
- alarm_bcd  out  16  same digit format, registered
- disp_word  out  16  word for the hex/7-seg driver, registered
- mode  out  2  current state encoding
- alarm_ring  out  1  alarm active, registered

## Operation
- States: RUN=0, SET_TIME=1, SET_ALARM=2.
- The next state is evaluated every cycle:
  - sw_time_set=1 → SET_TIME.
  - else sw_alarm_set=1 → SET_ALARM.
  - else → RUN.
  - sw_time_set has priority when both switches are set.
- Each cycle, rising edges of btn_min and btn_hour are detected against registered previous levels.
  - In a SET state, a detected edge sets a pending flag: pend_min or pend_hour.
  - In RUN, a detected edge sets nothing.
- Increment unit ops:
  - TICK: minute+1 with carry into hour; 23:59→00:00.
  - MIN: minute+1 wraps 59→00 with no carry; hour unchanged.
  - HOUR: hour+1 wraps 23→00; minute unchanged.
- Arbitration allows one op per cycle, in this priority order:
  1. TICK on time_bcd. Granted only in RUN or SET_ALARM. In SET_TIME the tick is dropped, so the clock is paused.
  2. pend_min on the register selected by mode: time_bcd in SET_TIME, alarm_bcd in SET_ALARM.
  3. pend_hour on the same target.
- A granted pending flag clears on the same edge. A flag that loses arbitration is held until it is granted.
- A repeat edge while its flag is already pending is absorbed; flags do not count.
- Any state change clears both pending flags.
- disp_word:
  - alarm_bcd in SET_ALARM.
  - alarm_bcd in RUN when sw_alarm_view=1.
  - time_bcd otherwise.
- Alarm:
  - alarm_ring sets when a TICK grant makes the new time_bcd equal alarm_bcd, alarm_en=1, and state is RUN or SET_ALARM.
  - It clears on a rising edge of either button in any state, on alarm_en=0, or on entry to SET_TIME.
  - Clear wins over a simultaneous set.
- Digit values are always legal BCD. Hour range is 00–23; minute range is 00–59.

## Timing
- Reset values: time_bcd=16'h0000, alarm_bcd=16'h0000, disp_word=16'h0000, mode=RUN, alarm_ring=0, pending flags=0, previous button levels=0.
- Reset is asynchronous and takes effect mid-operation. No pending request survives reset.
- Tick: one_minute sampled high at edge k → time_bcd updated at edge k.
- Button: level first sampled high at edge k → pending set at k → register updated at k+1. If a TICK wins at k+1, the update moves to k+2.
- disp_word follows a register or mode change one cycle later.
- mode changes on the edge after the switch is sampled. Switches are assumed already synchronized.
- alarm_ring asserts on the edge after the matching TICK update, i.e. k+1.

## Structure
- Shared package al_pkg:
  - mode encodings RUN/SET_TIME/SET_ALARM.
  - op encodings TICK/MIN/HOUR.
  - BCD limit constants 23 and 59.
  - 16-bit BCD time typedef.
- Sub-module al_bcd_inc: combinational; inputs op and a 16-bit word, output the incremented word. One instance, shared via the arbiter mux. It replaces the existing bcd_clock in this path.
- al_mode_ctrl holds the state register, edge detectors, pending flags, arbiter, time/alarm registers, display mux and alarm latch.

## Test plan
- Reset, RUN, time 23:59, one one_minute pulse → time_bcd=16'h0000 at that edge; alarm_bcd still 0000.
- SET_TIME at 12:59, btn_min edge → 12:00 two edges later. btn_hour edge with time 23:00 → 00:00. one_minute pulses in this mode leave time unchanged.
- SET_ALARM: btn_min edge such that pend_min is granted on the same edge as a one_minute pulse → time +1 first, alarm +1 exactly one cycle later, no lost request.
- Alarm 07:30, alarm_en=1, RUN at 07:29, tick → time 07:30, alarm_ring=1 next edge. btn_hour edge → alarm_ring=0 and time unchanged.
- Pending btn_hour held behind a tick, then sw_alarm_set dropped → flag cleared, alarm_bcd unchanged. sw_time_set and sw_alarm_set both high → mode=SET_TIME.
- Assert int_reset asynchronously mid-SET_ALARM with a request pending → all outputs zero and mode=RUN immediately. No increment after release.

Source files
------------

// File: rtl/al_pkg.sv
// Shared encodings and limits for the alarm-clock mode controller.
// Time words are packed BCD: {ms_hour, ls_hour, ms_min, ls_min}.
package al_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        OP_TICK = 2'd0,
        OP_MIN  = 2'd1,
        OP_HOUR = 2'd2
    } op_e;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;

    typedef logic [15:0] bcd_time_t;

endpackage

// File: rtl/al_mode_ctrl_if.sv
// Signal bundle for al_mode_ctrl: user/timebase inputs and registered outputs.
// The master side drives the switches, buttons and minute tick; the slave side is the controller.
interface al_mode_ctrl_if;
    logic        one_minute;
    logic        btn_min;
    logic        btn_hour;
    logic        sw_time_set;
    logic        sw_alarm_set;
    logic        sw_alarm_view;
    logic        alarm_en;
    logic [15:0] time_bcd;
    logic [15:0] alarm_bcd;
    logic [15:0] disp_word;
    logic [1:0]  mode;
    logic        alarm_ring;

    modport master (
        output one_minute, btn_min, btn_hour, sw_time_set, sw_alarm_set,
               sw_alarm_view, alarm_en,
        input  time_bcd, alarm_bcd, disp_word, mode, alarm_ring
    );

    modport slave (
        input  one_minute, btn_min, btn_hour, sw_time_set, sw_alarm_set,
               sw_alarm_view, alarm_en,
        output time_bcd, alarm_bcd, disp_word, mode, alarm_ring
    );
endinterface

// File: rtl/al_bcd_inc.sv
// Combinational BCD increment unit shared by the timekeeping tick and the set buttons.
// TICK carries minutes into hours; MIN and HOUR wrap their own field only.
module al_bcd_inc
    import al_pkg::*;
(
    input  op_e       op,
    input  bcd_time_t din,
    output bcd_time_t dout
);

    logic [7:0] min_inc;
    logic [7:0] hour_inc;
    logic       min_wrap;

    always_comb begin
        min_wrap = (din[7:0] == MIN_MAX);

        if (min_wrap) begin
            min_inc = 8'h00;
        end else if (din[3:0] == 4'd9) begin
            min_inc = {din[7:4] + 4'd1, 4'd0};
        end else begin
            min_inc = {din[7:4], din[3:0] + 4'd1};
        end

        if (din[15:8] == HOUR_MAX) begin
            hour_inc = 8'h00;
        end else if (din[11:8] == 4'd9) begin
            hour_inc = {din[15:12] + 4'd1, 4'd0};
        end else begin
            hour_inc = {din[15:12], din[11:8] + 4'd1};
        end

        case (op)
            OP_TICK: dout = min_wrap ? {hour_inc, 8'h00} : {din[15:8], min_inc};
            OP_MIN:  dout = {din[15:8], min_inc};
            OP_HOUR: dout = {hour_inc, din[7:0]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/al_mode_ctrl.sv
// Alarm-clock mode controller: mode FSM, button edge capture, one-op-per-cycle
// arbitration of the shared BCD incrementer, time/alarm registers, display mux, alarm latch.
module al_mode_ctrl
    import al_pkg::*;
(
    input  logic        MCLK,
    input  logic        int_reset,
    input  logic        one_minute,
    input  logic        btn_min,
    input  logic        btn_hour,
    input  logic        sw_time_set,
    input  logic        sw_alarm_set,
    input  logic        sw_alarm_view,
    input  logic        alarm_en,
    output logic [15:0] time_bcd,
    output logic [15:0] alarm_bcd,
    output logic [15:0] disp_word,
    output logic [1:0]  mode,
    output logic        alarm_ring
);

    mode_e     state_q, state_d;
    logic      btn_min_q, btn_min_d, btn_hour_q, btn_hour_d;
    logic      pend_min_q, pend_min_d, pend_hour_q, pend_hour_d;
    bcd_time_t time_q, time_d, alarm_q, alarm_d, disp_q, disp_d;
    logic      ring_q, ring_d, match_q, match_d;

    logic      rise_min, rise_hour, in_set, state_chg;
    logic      grant_tick, grant_min, grant_hour;
    op_e       inc_op;
    bcd_time_t inc_in, inc_out;

    al_bcd_inc u_inc (
        .op   (inc_op),
        .din  (inc_in),
        .dout (inc_out)
    );

    // Arbitration and incrementer operand select; the tick always wins the shared unit.
    always_comb begin
        state_d = MODE_RUN;
        if (sw_time_set) begin
            state_d = MODE_SET_TIME;
        end else if (sw_alarm_set) begin
            state_d = MODE_SET_ALARM;
        end
        state_chg  = (state_d != state_q);
        in_set     = (state_q != MODE_RUN);
        rise_min   = btn_min & ~btn_min_q;
        rise_hour  = btn_hour & ~btn_hour_q;
        grant_tick = one_minute && (state_q != MODE_SET_TIME);
        grant_min  = !grant_tick && in_set && pend_min_q;
        grant_hour = !grant_tick && !grant_min && in_set && pend_hour_q;

        inc_op = OP_TICK;
        inc_in = time_q;
        if (!grant_tick) begin
            inc_op = grant_min ? OP_MIN : OP_HOUR;
            inc_in = (state_q == MODE_SET_ALARM) ? alarm_q : time_q;
        end
    end

    always_comb begin
        btn_min_d  = btn_min;
        btn_hour_d = btn_hour;
        time_d     = time_q;
        alarm_d    = alarm_q;

        if (grant_tick) begin
            time_d = inc_out;
        end else if (grant_min || grant_hour) begin
            if (state_q == MODE_SET_ALARM) begin
                alarm_d = inc_out;
            end else begin
                time_d = inc_out;
            end
        end

        // Flags are presence bits, not counters; a mode change discards them.
        pend_min_d  = (pend_min_q & ~grant_min) | (rise_min & in_set);
        pend_hour_d = (pend_hour_q & ~grant_hour) | (rise_hour & in_set);
        if (state_chg) begin
            pend_min_d  = 1'b0;
            pend_hour_d = 1'b0;
        end

        // The match is staged one cycle so the ring follows the tick update.
        match_d = grant_tick && alarm_en && (inc_out == alarm_q);
        ring_d  = ring_q | match_q;
        if (rise_min || rise_hour || !alarm_en ||
            (state_d == MODE_SET_TIME && state_q != MODE_SET_TIME)) begin
            ring_d = 1'b0;
        end

        if (state_q == MODE_SET_ALARM || (state_q == MODE_RUN && sw_alarm_view)) begin
            disp_d = alarm_q;
        end else begin
            disp_d = time_q;
        end
    end

    always_ff @(posedge MCLK or posedge int_reset) begin
        if (int_reset) begin
            state_q     <= MODE_RUN;
            btn_min_q   <= 1'b0;
            btn_hour_q  <= 1'b0;
            pend_min_q  <= 1'b0;
            pend_hour_q <= 1'b0;
            time_q      <= 16'h0000;
            alarm_q     <= 16'h0000;
            disp_q      <= 16'h0000;
            ring_q      <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_min_q   <= btn_min_d;
            btn_hour_q  <= btn_hour_d;
            pend_min_q  <= pend_min_d;
            pend_hour_q <= pend_hour_d;
            time_q      <= time_d;
            alarm_q     <= alarm_d;
            disp_q      <= disp_d;
            ring_q      <= ring_d;
            match_q     <= match_d;
        end
    end

    assign time_bcd   = time_q;
    assign alarm_bcd  = alarm_q;
    assign disp_word  = disp_q;
    assign mode       = state_q;
    assign alarm_ring = ring_q;

endmodule

// File: tb/tb_al_mode_ctrl.sv
// Directed bench for al_mode_ctrl: per-scenario tasks with hand-computed expectations.
module tb_al_mode_ctrl;

    logic MCLK;
    logic int_reset;
    int   n_checks;
    int   n_pass;

    al_mode_ctrl_if ifc ();

    al_mode_ctrl dut (
        .MCLK          (MCLK),
        .int_reset     (int_reset),
        .one_minute    (ifc.one_minute),
        .btn_min       (ifc.btn_min),
        .btn_hour      (ifc.btn_hour),
        .sw_time_set   (ifc.sw_time_set),
        .sw_alarm_set  (ifc.sw_alarm_set),
        .sw_alarm_view (ifc.sw_alarm_view),
        .alarm_en      (ifc.alarm_en),
        .time_bcd      (ifc.time_bcd),
        .alarm_bcd     (ifc.alarm_bcd),
        .disp_word     (ifc.disp_word),
        .mode          (ifc.mode),
        .alarm_ring    (ifc.alarm_ring)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge MCLK);
            #1;
        end
    endtask

    task automatic do_reset();
        int_reset         = 1'b1;
        ifc.one_minute    = 1'b0;
        ifc.btn_min       = 1'b0;
        ifc.btn_hour      = 1'b0;
        ifc.sw_time_set   = 1'b0;
        ifc.sw_alarm_set  = 1'b0;
        ifc.sw_alarm_view = 1'b0;
        ifc.alarm_en      = 1'b0;
        step(2);
        int_reset = 1'b0;
        step(1);
    endtask

    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.btn_min = 1'b1;
            step(1);
            ifc.btn_min = 1'b0;
            step(1);
        end
    endtask

    task automatic press_hour(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.btn_hour = 1'b1;
            step(1);
            ifc.btn_hour = 1'b0;
            step(1);
        end
    endtask

    task automatic test_reset();
        ifc.sw_alarm_set = 1'b1;
        step(1);
        press_min(4);
        do_reset();
        n_checks++; if (ifc.time_bcd !== 16'h0000) $display("FAIL reset_time: got %h exp %h", ifc.time_bcd, 16'h0000); else n_pass++;
        n_checks++; if (ifc.alarm_bcd !== 16'h0000) $display("FAIL reset_alarm: got %h exp %h", ifc.alarm_bcd, 16'h0000); else n_pass++;
        n_checks++; if (ifc.disp_word !== 16'h0000) $display("FAIL reset_disp: got %h exp %h", ifc.disp_word, 16'h0000); else n_pass++;
        n_checks++; if (ifc.mode !== 2'd0) $display("FAIL reset_mode: got %0d exp %0d", ifc.mode, 0); else n_pass++;
        n_checks++; if (ifc.alarm_ring !== 1'b0) $display("FAIL reset_ring: got %b exp %b", ifc.alarm_ring, 1'b0); else n_pass++;
    endtask

    task automatic test_tick_wrap();
        do_reset();
        ifc.sw_time_set = 1'b1;
        step(1);
        press_hour(23);
        press_min(59);
        n_checks++; if (ifc.time_bcd !== 16'h2359) $display("FAIL wrap_setup: got %h exp %h", ifc.time_bcd, 16'h2359); else n_pass++;
        ifc.sw_time_set = 1'b0;
        step(1);
        ifc.one_minute = 1'b1;
        step(1);
        ifc.one_minute = 1'b0;
        n_checks++; if (ifc.time_bcd !== 16'h0000) $display("FAIL wrap_time: got %h exp %h", ifc.time_bcd, 16'h0000); else n_pass++;
        n_checks++; if (ifc.alarm_bcd !== 16'h0000) $display("FAIL wrap_alarm: got %h exp %h", ifc.alarm_bcd, 16'h0000); else n_pass++;
        step(1);
        n_checks++; if (ifc.disp_word !== 16'h0000) $display("FAIL wrap_disp: got %h exp %h", ifc.disp_word, 16'h0000); else n_pass++;
    endtask

    task automatic test_set_time();
        do_reset();
        ifc.sw_time_set = 1'b1;
        step(1);
        n_checks++; if (ifc.mode !== 2'd1) $display("FAIL set_time_mode: got %0d exp %0d", ifc.mode, 1); else n_pass++;
        press_hour(12);
        press_min(59);
        n_checks++; if (ifc.time_bcd !== 16'h1259) $display("FAIL set_time_1259: got %h exp %h", ifc.time_bcd, 16'h1259); else n_pass++;
        ifc.btn_min = 1'b1;
        step(1);
        n_checks++; if (ifc.time_bcd !== 16'h1259) $display("FAIL set_min_latency: got %h exp %h", ifc.time_bcd, 16'h1259); else n_pass++;
        ifc.btn_min = 1'b0;
        step(1);
        n_checks++; if (ifc.time_bcd !== 16'h1200) $display("FAIL set_min_wrap: got %h exp %h", ifc.time_bcd, 16'h1200); else n_pass++;
        press_hour(11);
        n_checks++; if (ifc.time_bcd !== 16'h2300) $display("FAIL set_hour_23: got %h exp %h", ifc.time_bcd, 16'h2300); else n_pass++;
        press_hour(1);
        n_checks++; if (ifc.time_bcd !== 16'h0000) $display("FAIL set_hour_wrap: got %h exp %h", ifc.time_bcd, 16'h0000); else n_pass++;
        press_min(5);
        for (int i = 0; i < 3; i++) begin
            ifc.one_minute = 1'b1;
            step(1);
            ifc.one_minute = 1'b0;
            step(1);
        end
        n_checks++; if (ifc.time_bcd !== 16'h0005) $display("FAIL set_time_paused: got %h exp %h", ifc.time_bcd, 16'h0005); else n_pass++;
    endtask

    task automatic test_arb_collision();
        do_reset();
        ifc.sw_alarm_set = 1'b1;
        step(1);
        ifc.btn_min = 1'b1;
        step(1);
        ifc.btn_min    = 1'b0;
        ifc.one_minute = 1'b1;
        step(1);
        ifc.one_minute = 1'b0;
        n_checks++; if (ifc.time_bcd !== 16'h0001) $display("FAIL arb_tick_time: got %h exp %h", ifc.time_bcd, 16'h0001); else n_pass++;
        n_checks++; if (ifc.alarm_bcd !== 16'h0000) $display("FAIL arb_alarm_held: got %h exp %h", ifc.alarm_bcd, 16'h0000); else n_pass++;
        step(1);
        n_checks++; if (ifc.alarm_bcd !== 16'h0001) $display("FAIL arb_alarm_late: got %h exp %h", ifc.alarm_bcd, 16'h0001); else n_pass++;
        step(1);
        n_checks++; if (ifc.alarm_bcd !== 16'h0001) $display("FAIL arb_no_double: got %h exp %h", ifc.alarm_bcd, 16'h0001); else n_pass++;
        n_checks++; if (ifc.disp_word !== 16'h0001) $display("FAIL arb_disp_alarm: got %h exp %h", ifc.disp_word, 16'h0001); else n_pass++;
    endtask

    task automatic test_alarm_ring();
        do_reset();
        ifc.sw_alarm_set = 1'b1;
        step(1);
        press_hour(7);
        press_min(30);
        ifc.sw_alarm_set = 1'b0;
        ifc.sw_time_set  = 1'b1;
        step(1);
        press_hour(7);
        press_min(29);
        ifc.sw_time_set = 1'b0;
        ifc.alarm_en    = 1'b1;
        ifc.sw_alarm_view = 1'b1;
        step(2);
        n_checks++; if (ifc.disp_word !== 16'h0730) $display("FAIL view_alarm_disp: got %h exp %h", ifc.disp_word, 16'h0730); else n_pass++;
        ifc.sw_alarm_view = 1'b0;
        step(1);
        n_checks++; if (ifc.disp_word !== 16'h0729) $display("FAIL view_time_disp: got %h exp %h", ifc.disp_word, 16'h0729); else n_pass++;
        ifc.one_minute = 1'b1;
        step(1);
        ifc.one_minute = 1'b0;
        n_checks++; if (ifc.time_bcd !== 16'h0730) $display("FAIL ring_time: got %h exp %h", ifc.time_bcd, 16'h0730); else n_pass++;
        n_checks++; if (ifc.alarm_ring !== 1'b0) $display("FAIL ring_early: got %b exp %b", ifc.alarm_ring, 1'b0); else n_pass++;
        step(1);
        n_checks++; if (ifc.alarm_ring !== 1'b1) $display("FAIL ring_set: got %b exp %b", ifc.alarm_ring, 1'b1); else n_pass++;
        step(2);
        n_checks++; if (ifc.alarm_ring !== 1'b1) $display("FAIL ring_hold: got %b exp %b", ifc.alarm_ring, 1'b1); else n_pass++;
        ifc.btn_hour = 1'b1;
        step(1);
        ifc.btn_hour = 1'b0;
        n_checks++; if (ifc.alarm_ring !== 1'b0) $display("FAIL ring_clear: got %b exp %b", ifc.alarm_ring, 1'b0); else n_pass++;
        step(2);
        n_checks++; if (ifc.time_bcd !== 16'h0730) $display("FAIL ring_time_kept: got %h exp %h", ifc.time_bcd, 16'h0730); else n_pass++;
        n_checks++; if (ifc.alarm_bcd !== 16'h0730) $display("FAIL ring_alarm_kept: got %h exp %h", ifc.alarm_bcd, 16'h0730); else n_pass++;
    endtask

    task automatic test_pend_clear();
        do_reset();
        ifc.sw_alarm_set = 1'b1;
        step(1);
        ifc.btn_hour = 1'b1;
        step(1);
        ifc.btn_hour     = 1'b0;
        ifc.one_minute   = 1'b1;
        ifc.sw_alarm_set = 1'b0;
        step(1);
        ifc.one_minute = 1'b0;
        n_checks++; if (ifc.time_bcd !== 16'h0001) $display("FAIL pclr_tick: got %h exp %h", ifc.time_bcd, 16'h0001); else n_pass++;
        n_checks++; if (ifc.mode !== 2'd0) $display("FAIL pclr_mode: got %0d exp %0d", ifc.mode, 0); else n_pass++;
        ifc.sw_alarm_set = 1'b1;
        step(3);
        n_checks++; if (ifc.alarm_bcd !== 16'h0000) $display("FAIL pclr_alarm: got %h exp %h", ifc.alarm_bcd, 16'h0000); else n_pass++;
        ifc.sw_time_set = 1'b1;
        step(1);
        n_checks++; if (ifc.mode !== 2'd1) $display("FAIL both_sw_mode: got %0d exp %0d", ifc.mode, 1); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ifc.sw_alarm_set = 1'b1;
        step(1);
        press_min(3);
        ifc.one_minute = 1'b1;
        step(1);
        ifc.one_minute = 1'b0;
        ifc.alarm_en   = 1'b1;
        ifc.btn_min    = 1'b1;
        step(1);
        #2;
        int_reset = 1'b1;
        #1;
        n_checks++; if (ifc.time_bcd !== 16'h0000) $display("FAIL async_time: got %h exp %h", ifc.time_bcd, 16'h0000); else n_pass++;
        n_checks++; if (ifc.alarm_bcd !== 16'h0000) $display("FAIL async_alarm: got %h exp %h", ifc.alarm_bcd, 16'h0000); else n_pass++;
        n_checks++; if (ifc.disp_word !== 16'h0000) $display("FAIL async_disp: got %h exp %h", ifc.disp_word, 16'h0000); else n_pass++;
        n_checks++; if (ifc.mode !== 2'd0) $display("FAIL async_mode: got %0d exp %0d", ifc.mode, 0); else n_pass++;
        step(1);
        ifc.btn_min = 1'b0;
        int_reset   = 1'b0;
        step(4);
        n_checks++; if (ifc.alarm_bcd !== 16'h0000) $display("FAIL post_reset_alarm: got %h exp %h", ifc.alarm_bcd, 16'h0000); else n_pass++;
        n_checks++; if (ifc.time_bcd !== 16'h0000) $display("FAIL post_reset_time: got %h exp %h", ifc.time_bcd, 16'h0000); else n_pass++;
        n_checks++; if (ifc.mode !== 2'd2) $display("FAIL post_reset_mode: got %0d exp %0d", ifc.mode, 2); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        do_reset();
        test_reset();
        test_tick_wrap();
        test_set_time();
        test_arb_collision();
        test_alarm_ring();
        test_pend_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
